mips_multicycle_control: RTL and testbench

Control FSM for the multi-cycle successor of the single-cycle MIPS core. It sequences fetch, decode, execute, memory and writeback over several cycles, so one shared memory port and one ALU serve all steps. It adds a ready/request handshake to that memory with a wait timeout, and an illegal-opcode trap. It sits between the instruction register fields and the shared datapath muxes and enables.

---
 rtl/mips_pkg.sv | 75 +++++++
 rtl/mips_mc_decode.sv | 36 +++
 rtl/mips_multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control path: instruction fields,
// datapath mux encodings, ALU op codes and FSM state codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;
  localparam logic [1:0] M2R_LUI = 2'd3;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_R     = 4'd8;
  localparam logic [3:0] S_WB_I     = 4'd9;
  localparam logic [3:0] S_WB_MEM   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  function automatic logic [2:0] alu_op_for_imm(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// DECODE-state successor function: maps opcode/funct to the next state and
// flags encodings the core does not implement.
module mips_mc_decode
  import mips_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_next_state,
  output logic       o_illegal
);

  always_comb begin
    o_next_state = S_FETCH;
    o_illegal    = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL: o_next_state = S_EXEC_R;
          FN_JR:   o_next_state = S_JR;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI: o_next_state = S_EXEC_I;
      OP_LUI:                   o_next_state = S_WB_I;
      OP_LW, OP_SW:             o_next_state = S_MEM_ADDR;
      OP_BEQ, OP_BNE:           o_next_state = S_BRANCH;
      OP_J, OP_JAL:             o_next_state = S_JUMP;
      default:                  o_illegal = 1'b1;
    endcase
    // Without trapping, a bad encoding simply retires and fetch resumes.
    if (o_illegal) o_next_state = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences the shared memory port and ALU,
// with a memory wait timeout and an illegal-instruction trap.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT_LIMIT  = 15,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] o_state_dbg
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_LIMIT - 1);

  logic [3:0] r_state;
  logic [3:0] w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic       r_illegal;
  logic       r_bus_error;
  logic [3:0] w_dec_nxt;
  logic       w_dec_illegal;
  logic       w_waiting;
  logic       w_timeout;
  logic       w_unused;

  // The branch condition gates pc_write_cond in the datapath, not here.
  assign w_unused = branch_taken;

  mips_mc_decode #(.TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)) u_decode (
    .i_opcode    (opcode),
    .i_funct     (funct),
    .o_next_state(w_dec_nxt),
    .o_illegal   (w_dec_illegal)
  );

  assign w_waiting   = mem_req && !mem_ready;
  assign w_timeout   = w_waiting && (r_wait_cnt == WAIT_LAST);
  assign illegal     = r_illegal;
  assign bus_error   = r_bus_error;
  assign o_state_dbg = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     w_state_nxt = S_FETCH;
      S_FETCH:    if (mem_ready) w_state_nxt = S_DECODE;
      S_DECODE:   w_state_nxt = w_dec_nxt;
      S_EXEC_R:   w_state_nxt = S_WB_R;
      S_EXEC_I:   w_state_nxt = S_WB_I;
      S_MEM_ADDR: w_state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_state_nxt = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) w_state_nxt = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: w_state_nxt = S_FETCH;
      S_TRAP:     w_state_nxt = S_TRAP;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_TRAP;
  end

  // Any state change restarts the wait count, so each memory state starts at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 8'd0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_wait_cnt <= 8'd0;
      else if (w_waiting)         r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout) r_bus_error <= 1'b1;
      if ((r_state == S_DECODE) && w_dec_illegal && TRAP_ON_ILLEGAL) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = RDST_RT;
    mem_to_reg    = M2R_ALU;
    instr_done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        instr_done = w_dec_illegal && !TRAP_ON_ILLEGAL;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = alu_op_for_imm(opcode);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = RDST_RD;
        instr_done = 1'b1;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LUI) ? M2R_LUI : M2R_ALU;
        instr_done = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCS_JUMP;
        instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = RDST_RA;
          mem_to_reg = M2R_PC;
        end
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_source  = PCS_RS;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instance 0 traps (wait limit 4),
// instance 1 retires bad encodings as NOPs (wait limit 15).
module tb_mips_multicycle_control;
  import mips_pkg::*;

  localparam int LIMIT_A = 4;

  typedef enum {P_IDLE, P_FETCH, P_DECODE, P_ALU_R, P_ALU_I, P_ADDR, P_LOAD, P_STORE,
                P_WR_R, P_WR_I, P_WR_MEM, P_BR, P_J, P_JR, P_TRAP} phase_e;
  typedef struct {
    phase_e ph;
    logic   rdy;
    logic   ill;
    logic   berr;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [5:0] opcode, funct;
  logic       branch_taken, mem_ready;

  logic [1:0]      mem_req_w, mem_we_w, iord_w, ir_write_w, pc_write_w, pc_write_cond_w;
  logic [1:0]      alu_src_a_w, reg_write_w, instr_done_w, illegal_w, bus_error_w;
  logic [1:0][1:0] pc_source_w, alu_src_b_w, reg_dst_w, mem_to_reg_w;
  logic [1:0][2:0] alu_op_w;
  logic [1:0][3:0] state_dbg_w;
  logic [1:0][21:0] obs_vec;

  mips_multicycle_control #(.MEM_WAIT_LIMIT(LIMIT_A), .TRAP_ON_ILLEGAL(1'b1)) u_dut (
    .clk(clk), .reset(rst_a), .opcode(opcode), .funct(funct),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req_w[0]), .mem_we(mem_we_w[0]), .iord(iord_w[0]),
    .ir_write(ir_write_w[0]), .pc_write(pc_write_w[0]), .pc_write_cond(pc_write_cond_w[0]),
    .pc_source(pc_source_w[0]), .alu_src_a(alu_src_a_w[0]), .alu_src_b(alu_src_b_w[0]),
    .alu_op(alu_op_w[0]), .reg_write(reg_write_w[0]), .reg_dst(reg_dst_w[0]),
    .mem_to_reg(mem_to_reg_w[0]), .instr_done(instr_done_w[0]), .illegal(illegal_w[0]),
    .bus_error(bus_error_w[0]), .o_state_dbg(state_dbg_w[0])
  );

  mips_multicycle_control #(.MEM_WAIT_LIMIT(15), .TRAP_ON_ILLEGAL(1'b0)) u_nop (
    .clk(clk), .reset(rst_b), .opcode(opcode), .funct(funct),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req_w[1]), .mem_we(mem_we_w[1]), .iord(iord_w[1]),
    .ir_write(ir_write_w[1]), .pc_write(pc_write_w[1]), .pc_write_cond(pc_write_cond_w[1]),
    .pc_source(pc_source_w[1]), .alu_src_a(alu_src_a_w[1]), .alu_src_b(alu_src_b_w[1]),
    .alu_op(alu_op_w[1]), .reg_write(reg_write_w[1]), .reg_dst(reg_dst_w[1]),
    .mem_to_reg(mem_to_reg_w[1]), .instr_done(instr_done_w[1]), .illegal(illegal_w[1]),
    .bus_error(bus_error_w[1]), .o_state_dbg(state_dbg_w[1])
  );

  for (genvar k = 0; k < 2; k++) begin : g_pack
    assign obs_vec[k] = {mem_req_w[k], mem_we_w[k], iord_w[k], ir_write_w[k], pc_write_w[k],
                         pc_write_cond_w[k], pc_source_w[k], alu_src_a_w[k], alu_src_b_w[k],
                         alu_op_w[k], reg_write_w[k], reg_dst_w[k], mem_to_reg_w[k],
                         instr_done_w[k], illegal_w[k], bus_error_w[k]};
  end

  int n_checks = 0;
  int n_pass   = 0;
  step_t plan_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] r_fns[$] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08};
    logic [5:0] ops[$]   = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    if (op == 6'h00) begin
      foreach (r_fns[i]) if (r_fns[i] == fn) return 1'b1;
      return 1'b0;
    end
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Cycles from first FETCH cycle to the retiring cycle with zero memory waits.
  function automatic int base_latency(input logic [5:0] op, input logic [5:0] fn);
    if (!legal(op, fn)) return 2;
    if (op == 6'h00) return (fn == 6'h08) ? 3 : 4;
    case (op)
      6'h23:                      return 5;
      6'h08, 6'h0C, 6'h0D, 6'h2B: return 4;
      default:                    return 3;
    endcase
  endfunction

  // Expected control word for one cycle, built from the per-step rules.
  function automatic logic [21:0] exp_ctl(input step_t s, input logic [5:0] op, input logic nop_ill);
    logic mreq, mwe, io, irw, pcw, pcwc, srca, rw, done;
    logic [1:0] pcs, srcb, rdst, m2r;
    logic [2:0] aop;
    {mreq, mwe, io, irw, pcw, pcwc, srca, rw, done} = '0;
    {pcs, srcb, rdst, m2r} = '0;
    aop = ALU_ADD;
    case (s.ph)
      P_FETCH:  begin mreq = 1; srcb = 2'd1; irw = s.rdy; pcw = s.rdy; end
      P_DECODE: begin srcb = 2'd3; done = nop_ill; end
      P_ALU_R:  begin srca = 1; aop = ALU_RTYPE; end
      P_ALU_I:  begin
        srca = 1; srcb = 2'd2;
        aop = (op == 6'h0C) ? ALU_AND : (op == 6'h0D) ? ALU_OR : ALU_ADD;
      end
      P_ADDR:   begin srca = 1; srcb = 2'd2; end
      P_LOAD:   begin mreq = 1; io = 1; end
      P_STORE:  begin mreq = 1; mwe = 1; io = 1; done = s.rdy; end
      P_WR_R:   begin rw = 1; rdst = 2'd1; done = 1; end
      P_WR_I:   begin rw = 1; m2r = (op == 6'h0F) ? 2'd3 : 2'd0; done = 1; end
      P_WR_MEM: begin rw = 1; m2r = 2'd1; done = 1; end
      P_BR:     begin srca = 1; aop = ALU_SUB; pcwc = 1; pcs = 2'd1; done = 1; end
      P_J:      begin
        pcw = 1; pcs = 2'd2; done = 1;
        if (op == 6'h03) begin rw = 1; rdst = 2'd2; m2r = 2'd2; end
      end
      P_JR:     begin pcw = 1; pcs = 2'd3; done = 1; end
      default: ;
    endcase
    return {mreq, mwe, io, irw, pcw, pcwc, pcs, srca, srcb, aop, rw, rdst, m2r, done, s.ill, s.berr};
  endfunction

  task automatic push(input phase_e ph, input logic rdy, input logic ill = 1'b0, input logic berr = 1'b0);
    step_t s;
    s.ph = ph; s.rdy = rdy; s.ill = ill; s.berr = berr;
    plan_q.push_back(s);
  endtask

  task automatic push_mem(input phase_e ph, input int waits);
    for (int i = 0; i < waits; i++) push(ph, 1'b0);
    push(ph, 1'b1);
  endtask

  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm, input bit nop_mode);
    push_mem(P_FETCH, wf);
    push(P_DECODE, rnd());
    if (!legal(op, fn)) begin
      if (!nop_mode) for (int i = 0; i < 3; i++) push(P_TRAP, rnd(), 1'b1, 1'b0);
    end else if (op == 6'h00) begin
      if (fn == 6'h08) push(P_JR, rnd());
      else begin push(P_ALU_R, rnd()); push(P_WR_R, rnd()); end
    end else begin
      case (op)
        6'h08, 6'h0C, 6'h0D: begin push(P_ALU_I, rnd()); push(P_WR_I, rnd()); end
        6'h0F: push(P_WR_I, rnd());
        6'h23: begin push(P_ADDR, rnd()); push_mem(P_LOAD, wm); push(P_WR_MEM, rnd()); end
        6'h2B: begin push(P_ADDR, rnd()); push_mem(P_STORE, wm); end
        6'h04, 6'h05: push(P_BR, rnd());
        default: push(P_J, rnd());
      endcase
    end
  endtask

  // Plays the planned steps; entered and left at posedge+1.
  task automatic run_plan(input int sel, input logic [5:0] op, input logic [5:0] fn,
                          input int exp_lat, input int exp_dones, input string tag);
    int cyc = 0;
    int done_at = -1;
    int dones = 0;
    logic nop_ill;
    step_t s;
    nop_ill = (sel == 1) && !legal(op, fn);
    opcode = op;
    funct  = fn;
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      mem_ready    = s.rdy;
      branch_taken = rnd();
      @(negedge clk);
      check({tag, "_ctl"}, 32'(obs_vec[sel]), 32'(exp_ctl(s, op, nop_ill)));
      if (s.ph != P_IDLE) cyc++;
      if (instr_done_w[sel]) begin
        dones++;
        if (done_at < 0) done_at = cyc;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_dones"}, 32'(dones), 32'(exp_dones));
    if (exp_lat > 0) check({tag, "_latency"}, 32'(done_at), 32'(exp_lat));
  endtask

  task automatic one_instr(input int sel, input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm, input string tag);
    int lat;
    bit is_mem;
    is_mem = (op == 6'h23) || (op == 6'h2B);
    plan_instr(op, fn, wf, wm, sel == 1);
    lat = base_latency(op, fn) + wf + (is_mem ? wm : 0);
    if (!legal(op, fn) && sel == 0) run_plan(sel, op, fn, 0, 0, tag);
    else                            run_plan(sel, op, fn, lat, 1, tag);
  endtask

  // Resets both instances, then releases the selected one (IDLE this cycle).
  task automatic start(input int sel);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("reset_a", 32'(obs_vec[0]), 32'h0);
    check("reset_b", 32'(obs_vec[1]), 32'h0);
    @(posedge clk);
    #1;
    if (sel == 1) rst_b = 1'b1;
    else          rst_a = 1'b1;
    push(P_IDLE, rnd());
  endtask

  task automatic abort(input int sel, input string tag);
    if (sel == 1) rst_b = 1'b0;
    else          rst_a = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check(tag, 32'(obs_vec[sel]), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[$] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                           6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fns[$] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08};
    int idx;
    logic [5:0] op, fn;

    rst_a = 1'b0; rst_b = 1'b0;
    opcode = '0; funct = '0; mem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    start(0);
    one_instr(0, OP_RTYPE, FN_ADD, 0, 0, "add");
    one_instr(0, OP_LW, 6'h00, 0, 3, "lw_wait3");
    one_instr(0, OP_BEQ, 6'h00, 0, 0, "beq_a");
    one_instr(0, OP_BEQ, 6'h00, 1, 0, "beq_b");
    one_instr(0, OP_JAL, 6'h00, 0, 0, "jal");
    one_instr(0, OP_LUI, 6'h00, 2, 0, "lui");
    one_instr(0, OP_SW, 6'h00, 3, 3, "sw_edge");

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, ops.size() - 1);
      op  = ops[idx];
      fn  = fns[$urandom_range(0, fns.size() - 1)];
      one_instr(0, op, fn, $urandom_range(0, LIMIT_A - 1), $urandom_range(0, LIMIT_A - 1), "rand");
    end

    one_instr(0, 6'h3F, 6'h00, 0, 0, "ill_op");
    start(0);
    one_instr(0, OP_RTYPE, 6'h3F, 1, 0, "ill_fn");

    // Fetch never acknowledged: errors on the LIMIT_A-th waiting cycle.
    start(0);
    for (int i = 0; i < LIMIT_A; i++) push(P_FETCH, 1'b0);
    for (int i = 0; i < 3; i++) push(P_TRAP, rnd(), 1'b0, 1'b1);
    run_plan(0, OP_RTYPE, FN_ADD, 0, 0, "fetch_timeout");

    start(0);
    push(P_FETCH, 1'b1); push(P_DECODE, rnd()); push(P_ADDR, rnd());
    for (int i = 0; i < LIMIT_A; i++) push(P_STORE, 1'b0);
    for (int i = 0; i < 2; i++) push(P_TRAP, rnd(), 1'b0, 1'b1);
    run_plan(0, OP_SW, 6'h00, 0, 0, "store_timeout");

    start(0);
    push(P_FETCH, 1'b1); push(P_DECODE, rnd()); push(P_ADDR, rnd());
    push(P_STORE, 1'b0); push(P_STORE, 1'b0);
    run_plan(0, OP_SW, 6'h00, 0, 0, "sw_partial");
    abort(0, "abort_store");

    start(1);
    one_instr(1, 6'h3F, 6'h00, 1, 0, "nop_ill_op");
    one_instr(1, OP_RTYPE, FN_SUB, 0, 0, "nop_sub");
    one_instr(1, OP_RTYPE, 6'h3F, 0, 0, "nop_ill_fn");
    one_instr(1, OP_LW, 6'h00, 6, 9, "nop_lw_long");
    one_instr(1, OP_ANDI, 6'h00, 0, 0, "nop_andi");

    rst_a = 1'b0;
    rst_b = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
